// File: rtl/ahbl_bist_pkg.sv
// Shared constants, FSM state type and test-pattern helper for the AHB-Lite RAM BIST master.
package ahbl_bist_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0,
        ST_W1,
        ST_R1,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Word pattern: seed xor {~index, index}, optionally inverted for the second write/read pair.
    function automatic logic [31:0] pat(input logic [31:0] seed, input logic [15:0] idx, input logic inv);
        logic [31:0] p;
        p = seed ^ {~idx, idx};
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ahbl_bist_checker.sv
// Data-phase tracking, read-data compare, first-fail capture and saturating mismatch counter.
module ahbl_bist_checker
    import ahbl_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        ready,
    input  logic [1:0]  req_trans,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic        fail,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_exp,
    output logic [31:0] fail_got,
    output logic [15:0] err_count
);

    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    logic [31:0] dp_data;
    logic        mismatch;

    // Write data and read expectation share one register; during a read phase HWDATA is don't-care.
    assign wdata = dp_data;

    // A read data phase completes with wrong data.
    always_comb mismatch = ready && dp_valid && !dp_write && (rdata != dp_data);

    // Data-phase register: loads on every accepted address phase, held while the slave stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_data  <= '0;
        end else if (ready) begin
            dp_valid <= (req_trans == HTRANS_NONSEQ);
            if (req_trans == HTRANS_NONSEQ) begin
                dp_write <= req_write;
                dp_addr  <= req_addr;
                dp_data  <= req_data;
            end
        end
    end

    // Result registers: cleared on a new test, first mismatch captured, count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            err_count <= '0;
        end else if (clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            err_count <= '0;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (!fail) begin
                fail      <= 1'b1;
                fail_addr <= dp_addr;
                fail_exp  <= dp_data;
                fail_got  <= rdata;
            end
        end
    end

endmodule

// File: rtl/ahbl_ram_bist_master.sv
// AHB-Lite master running a four-pass write/read-compare march (P, ~P) over a word-addressed RAM.
module ahbl_ram_bist_master
    import ahbl_bist_pkg::*;
#(
    parameter int          AW   = 11,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_exp,
    output logic [31:0] fail_got,
    output logic [15:0] err_count,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);

    localparam int            IW   = AW - 2;
    localparam logic [IW-1:0] LAST = '1;

    state_t        state;
    state_t        after_drain;
    logic [IW-1:0] idx;
    logic [31:0]   seed_q;
    logic          accept_start;
    logic          inv;
    logic [31:0]   exp_data;

    function automatic logic [31:0] word_addr(input logic [IW-1:0] i);
        return BASE + (32'(i) << 2);
    endfunction

    function automatic state_t next_pass(input state_t s);
        case (s)
            ST_W0:   return ST_R0;
            ST_R0:   return ST_W1;
            ST_W1:   return ST_R1;
            default: return ST_DONE;
        endcase
    endfunction

    assign HSIZE = HSIZE_WORD;

    // Start is honoured only while idle; expected data of the word currently in address phase.
    always_comb begin
        accept_start = (state == ST_IDLE) && start;
        inv          = (state == ST_W1) || (state == ST_R1);
        exp_data     = pat(seed_q, 16'(idx), inv);
    end

    // Test sequencer: pass order, word index and registered address-phase outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            after_drain <= ST_IDLE;
            idx         <= '0;
            seed_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            HADDR       <= '0;
            HTRANS      <= HTRANS_IDLE;
            HWRITE      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_q <= seed;
                        busy   <= 1'b1;
                        idx    <= '0;
                        HADDR  <= BASE;
                        HTRANS <= HTRANS_NONSEQ;
                        HWRITE <= 1'b1;
                        state  <= ST_W0;
                    end
                end
                ST_W0, ST_R0, ST_W1, ST_R1: begin
                    if (HREADY) begin
                        if (idx == LAST) begin
                            // The last word's data phase is still open; DRAIN remembers where to resume.
                            after_drain <= next_pass(state);
                            HTRANS      <= HTRANS_IDLE;
                            HWRITE      <= 1'b0;
                            state       <= ST_DRAIN;
                        end else begin
                            idx   <= idx + IW'(1);
                            HADDR <= word_addr(idx + IW'(1));
                        end
                    end
                end
                ST_DRAIN: begin
                    if (HREADY) begin
                        idx   <= '0;
                        HADDR <= BASE;
                        if (after_drain == ST_DONE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= (after_drain == ST_W1);
                            state  <= after_drain;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ahbl_bist_checker u_checker (
        .clk       (HCLK),
        .rst       (HRESET),
        .clr       (accept_start),
        .ready     (HREADY),
        .req_trans (HTRANS),
        .req_write (HWRITE),
        .req_addr  (HADDR),
        .req_data  (exp_data),
        .rdata     (HRDATA),
        .wdata     (HWDATA),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_ahbl_ram_bist_master.sv
// Self-checking bench: behavioural AHB-Lite RAM slave with stuck-at faults and wait states,
// checked against a transfer-list / march-result reference model.
module tb_ahbl_ram_bist_master;

    localparam int          AW   = 11;
    localparam int          N    = 1 << (AW - 2);
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        fail;
    logic [31:0] fail_addr;
    logic [31:0] fail_exp;
    logic [31:0] fail_got;
    logic [15:0] err_count;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    logic [31:0] mem [N];
    int unsigned n_vec;
    int unsigned n_err;

    ahbl_ram_bist_master #(.AW(AW), .BASE(BASE)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got),
        .err_count (err_count),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transfer k of the whole test (0..4N-1): passes W0, R0, W1, R1 each sweep words 0..N-1.
    function automatic logic [31:0] ref_word(input logic [31:0] sd, input int k);
        logic [15:0] i16;
        logic [31:0] v;
        i16 = 16'(k % N);
        v   = sd ^ {~i16, i16};
        if ((k / N) >= 2) v = ~v;
        return v;
    endfunction

    task automatic run_bist(input logic [31:0] sd, input int stuck_i, input logic [31:0] stuck_m,
                            input int wmode, input int rst_at, input bit poke);
        int          k_addr, waits, done_cyc, post, limit, s_k, s_i;
        bit          prev_low, in_rst, finished, hr, s_valid, s_write, poked;
        logic [31:0] prev_haddr, prev_hwdata, w, st, mask;
        logic [1:0]  prev_htrans;
        logic        prev_hwrite;
        int          exp_errs;
        bit          exp_fail;
        logic [31:0] ef_addr, ef_exp, ef_got;

        exp_errs = 0; exp_fail = 0; ef_addr = '0; ef_exp = '0; ef_got = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                w    = ref_word(sd, 2 * p * N + i);
                mask = (i == stuck_i) ? stuck_m : 32'h0;
                st   = w & ~mask;
                if (st != w) begin
                    exp_errs++;
                    if (!exp_fail) begin
                        exp_fail = 1;
                        ef_addr  = BASE + 32'(i * 4);
                        ef_exp   = w;
                        ef_got   = st;
                    end
                end
            end
        end

        k_addr = 0; waits = 0; done_cyc = -1; post = 0; s_k = 0; s_i = 0;
        prev_low = 0; in_rst = 0; finished = 0; s_valid = 0; s_write = 0; poked = 0;
        prev_haddr = '0; prev_hwdata = '0; prev_htrans = '0; prev_hwrite = 1'b0;
        limit = 3 * (4 * N + 5) + 50;
        for (int i = 0; i < N; i++) mem[i] = $urandom;

        @(negedge HCLK);
        start  = 1'b1;
        seed   = sd;
        HREADY = 1'b1;
        for (int cyc = 1; cyc <= limit && !finished; cyc++) begin
            @(negedge HCLK);
            if (cyc == 1) begin
                start = 1'b0;
                seed  = $urandom;
                check_val("start_busy", 32'(busy), 32'd1);
                check_val("first_addr", HADDR, BASE);
                check_val("first_write", 32'(HWRITE), 32'd1);
                check_val("first_trans", 32'(HTRANS), 32'd2);
            end
            if (in_rst) begin
                if (post == 0) begin
                    HRESET = 1'b0;
                    check_val("rst_trans", 32'(HTRANS), 32'd0);
                    check_val("rst_busy", 32'(busy), 32'd0);
                    check_val("rst_errs", 32'(err_count), 32'd0);
                end
                check_val("rst_no_done", 32'(done), 32'd0);
                post++;
                if (post == 12) finished = 1;
            end else if (done_cyc >= 0) begin
                start = 1'b0;
                check_val("post_done", 32'({done, busy, HTRANS}), 32'd0);
                post++;
                if (post == 3) finished = 1;
            end else if (done) begin
                done_cyc = cyc;
                HREADY   = 1'b1;
                check_val("done_cycle", 32'(cyc), 32'(4 * N + 5 + waits));
                check_val("done_busy", 32'(busy), 32'd0);
                check_val("xfer_total", 32'(k_addr), 32'(4 * N));
                if (poke) begin
                    start = 1'b1;
                    seed  = ~sd;
                end
            end else begin
                check_val("trans_legal", 32'(HTRANS == 2'b00 || HTRANS == 2'b10), 32'd1);
                if (prev_low) begin
                    check_val("hold_addr", HADDR, prev_haddr);
                    check_val("hold_trans", 32'(HTRANS), 32'(prev_htrans));
                    check_val("hold_write", 32'(HWRITE), 32'(prev_hwrite));
                    check_val("hold_wdata", HWDATA, prev_hwdata);
                end
                if (poke) begin
                    start = (k_addr == N + 10) && !poked;
                    if (start) begin
                        poked = 1;
                        seed  = ~sd;
                    end
                end
                if (rst_at >= 0 && k_addr == rst_at && HTRANS == 2'b10) begin
                    HRESET  = 1'b1;
                    HREADY  = 1'b1;
                    HRDATA  = $urandom;
                    in_rst  = 1;
                    s_valid = 0;
                end else begin
                    case (wmode)
                        0:       hr = 1'b1;
                        1:       hr = (cyc % 2 == 1);
                        default: hr = ($urandom_range(0, 3) != 0);
                    endcase
                    if (!hr) waits++;
                    HREADY = hr;
                    HRDATA = $urandom;
                    if (hr) begin
                        if (s_valid) begin
                            if (s_write) begin
                                check_val("wdata", HWDATA, ref_word(sd, s_k));
                                mask = (s_i == stuck_i) ? stuck_m : 32'h0;
                                mem[s_i] = HWDATA & ~mask;
                            end else begin
                                HRDATA = mem[s_i];
                            end
                        end
                        if (HTRANS == 2'b10) begin
                            check_val("xfer_in_range", 32'(k_addr < 4 * N), 32'd1);
                            check_val("addr", HADDR, BASE + 32'((k_addr % N) * 4));
                            check_val("write", 32'(HWRITE), 32'(((k_addr / N) % 2) == 0));
                            s_valid = 1;
                            s_write = HWRITE;
                            s_i     = int'((HADDR - BASE) >> 2) % N;
                            s_k     = k_addr;
                            k_addr++;
                        end else begin
                            s_valid = 0;
                        end
                    end
                    prev_low    = !hr;
                    prev_haddr  = HADDR;
                    prev_htrans = HTRANS;
                    prev_hwrite = HWRITE;
                    prev_hwdata = HWDATA;
                end
            end
        end
        if (!finished) check_val("timeout", 32'd0, 32'd1);
        if (rst_at < 0) begin
            check_val("fail", 32'(fail), 32'(exp_fail));
            check_val("fail_addr", fail_addr, ef_addr);
            check_val("fail_exp", fail_exp, ef_exp);
            check_val("fail_got", fail_got, ef_got);
            check_val("err_count", 32'(err_count), 32'(exp_errs));
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        HRESET = 1'b1;
        start  = 1'b0;
        seed   = '0;
        HRDATA = '0;
        HREADY = 1'b1;
        repeat (2) @(negedge HCLK);
        check_val("rst_busy0", 32'(busy), 32'd0);
        check_val("rst_done0", 32'(done), 32'd0);
        check_val("rst_fail0", 32'(fail), 32'd0);
        check_val("rst_faddr0", fail_addr, 32'd0);
        check_val("rst_fexp0", fail_exp, 32'd0);
        check_val("rst_fgot0", fail_got, 32'd0);
        check_val("rst_errs0", 32'(err_count), 32'd0);
        check_val("rst_haddr0", HADDR, 32'd0);
        check_val("rst_htrans0", 32'(HTRANS), 32'd0);
        check_val("rst_hwrite0", 32'(HWRITE), 32'd0);
        check_val("rst_hwdata0", HWDATA, 32'd0);
        check_val("hsize", 32'(HSIZE), 32'd2);
        HRESET = 1'b0;

        // Fault-free, zero wait states.
        run_bist(32'h1234_5678, -1, 32'h0, 0, -1, 0);
        // HREADY low every other cycle.
        run_bist(32'h1234_5678, -1, 32'h0, 1, -1, 0);
        // Bit 3 of word 7 stuck at 0.
        run_bist(32'h1234_5678, 7, 32'h0000_0008, 0, -1, 0);
        check_val("s3_fail", 32'(fail), 32'd1);
        check_val("s3_addr", fail_addr, 32'h4000_001C);
        check_val("s3_exp", fail_exp, 32'hEDCC_567F);
        check_val("s3_got", fail_got, 32'hEDCC_5677);
        check_val("s3_errs", 32'(err_count), 32'd1);
        // Reset mid-W1 at word 100 (an earlier R0 mismatch makes err_count nonzero first), then a clean rerun.
        run_bist(32'h1234_5678, 5, 32'h0000_0001, 0, 2 * N + 100, 0);
        run_bist(32'h1234_5678, -1, 32'h0, 0, -1, 0);
        // Start pulses in R0 and in the DONE cycle must be ignored.
        run_bist(32'hA5A5_0F0F, -1, 32'h0, 0, -1, 1);
        // Randomised seeds, random wait states, random single stuck-at-0 bit.
        for (int r = 0; r < 2; r++) begin
            run_bist($urandom, int'($urandom_range(0, N - 1)), 32'h1 << $urandom_range(0, 31), 2, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
